// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, talks to instruction
// memory over a req/ack handshake and feeds instruction, PC and PC+4 to
// decode. Handles decode redirects (one-shot on a level) and freezes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC,
  input  logic        Request_Alt_PC,
  input  logic        WANT_FREEZE,
  output logic [31:0] IMem_Addr,
  output logic        IMem_Req,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic [31:0] Fetch_Count
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q, hold_instr_q, hold_pc_q, redir_pc_q;
  logic [31:0] instr_q, ipc_q, ipc4_q, cnt_q;
  logic        redir_seen_q;

  logic        new_redir;
  logic [31:0] alt_d, pc_plus4_d;

  // A redirect level only counts on its first cycle high.
  assign new_redir  = Request_Alt_PC && !redir_seen_q;
  assign alt_d      = {Alt_PC[31:2], 2'b00};
  assign pc_plus4_d = pc_q + 32'd4;

  // pc is not advanced while a request is outstanding or draining, so it is
  // always the address of the in-flight request.
  assign IMem_Addr = pc_q;
  assign IMem_Req  = (state_q != S_HOLD) && !RESET;

  assign Instr1_OUT         = instr_q;
  assign Instr_PC_OUT       = ipc_q;
  assign Instr_PC_Plus4_OUT = ipc4_q;
  assign Fetch_Count        = cnt_q;

  // Fetch FSM, PC, hold buffer and decode-facing output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      redir_pc_q   <= '0;
      redir_seen_q <= 1'b0;
      instr_q      <= NOP_INSTR;
      ipc_q        <= '0;
      ipc4_q       <= '0;
      cnt_q        <= '0;
    end else begin
      // Set by a new redirect, stays set while the level is held, clears on low.
      redir_seen_q <= Request_Alt_PC;
      case (state_q)
        S_FETCH: begin
          if (new_redir && IMem_Ack) begin
            instr_q <= NOP_INSTR;
            pc_q    <= alt_d;
          end else if (new_redir) begin
            // Request must complete before the new target can be issued.
            redir_pc_q <= alt_d;
            instr_q    <= NOP_INSTR;
            state_q    <= S_DRAIN;
          end else if (WANT_FREEZE) begin
            if (IMem_Ack) begin
              hold_instr_q <= IMem_Data;
              hold_pc_q    <= pc_q;
              pc_q         <= pc_plus4_d;
              state_q      <= S_HOLD;
            end
          end else if (IMem_Ack) begin
            instr_q <= IMem_Data;
            ipc_q   <= pc_q;
            ipc4_q  <= pc_plus4_d;
            pc_q    <= pc_plus4_d;
            cnt_q   <= cnt_q + 32'd1;
          end else begin
            instr_q <= NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (new_redir) begin
            instr_q <= NOP_INSTR;
            pc_q    <= alt_d;
            state_q <= S_FETCH;
          end else if (!WANT_FREEZE) begin
            instr_q <= hold_instr_q;
            ipc_q   <= hold_pc_q;
            ipc4_q  <= hold_pc_q + 32'd4;
            cnt_q   <= cnt_q + 32'd1;
            state_q <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (new_redir)                 redir_pc_q <= alt_d;
          if (new_redir || !WANT_FREEZE) instr_q    <= NOP_INSTR;
          if (IMem_Ack) begin
            // Abandoned data is dropped; the latest redirect target wins.
            pc_q    <= new_redir ? alt_d : redir_pc_q;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected deliveries are
// queued when the acking stimulus is driven and popped after the edge.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'hFC00_0000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Alt_PC;
  logic        Request_Alt_PC, WANT_FREEZE;
  logic [31:0] IMem_Addr;
  logic        IMem_Req, IMem_Ack;
  logic [31:0] IMem_Data;
  logic [31:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Fetch_Count;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RESET(RESET), .Alt_PC(Alt_PC), .Request_Alt_PC(Request_Alt_PC),
    .WANT_FREEZE(WANT_FREEZE), .IMem_Addr(IMem_Addr), .IMem_Req(IMem_Req),
    .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data), .Instr1_OUT(Instr1_OUT),
    .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
    .Fetch_Count(Fetch_Count)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
  exp_t        sb_q[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] ea, exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] data, input logic frz,
                       input logic ralt, input logic [31:0] alt);
    IMem_Ack = ack; IMem_Data = data; WANT_FREEZE = frz;
    Request_Alt_PC = ralt; Alt_PC = alt;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr; e.pc = pc;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      exp_cnt = exp_cnt + 32'd1;
      check({tag, "_instr"}, Instr1_OUT, e.instr);
      check({tag, "_pc"}, Instr_PC_OUT, e.pc);
      check({tag, "_pc4"}, Instr_PC_Plus4_OUT, e.pc + 32'd4);
      check({tag, "_cnt"}, Fetch_Count, exp_cnt);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_instr"}, Instr1_OUT, NOP);
    check({tag, "_pc"}, Instr_PC_OUT, 32'd0);
    check({tag, "_pc4"}, Instr_PC_Plus4_OUT, 32'd0);
    check({tag, "_cnt"}, Fetch_Count, 32'd0);
    check({tag, "_req"}, {31'd0, IMem_Req}, 32'd0);
    check({tag, "_addr"}, IMem_Addr, RST_PC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (2) tick();
    chk_reset("rst");
    RESET = 1'b0; #1;
    check("rst_rel_req", {31'd0, IMem_Req}, 32'd1);
    check("rst_rel_addr", IMem_Addr, RST_PC);
    ea = RST_PC; exp_cnt = 32'd0;

    // Zero-wait streaming.
    for (int i = 0; i < 3; i++) begin
      check("stream_addr", IMem_Addr, ea);
      drive(1'b1, ea | 32'd1, 1'b0, 1'b0, 32'd0);
      push(ea | 32'd1, ea);
      tick();
      pop_check("stream");
      ea = ea + 32'd4;
    end

    // Two wait states: address held, NOPs to decode, PC outputs unchanged.
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      check("ws_addr", IMem_Addr, ea);
      check("ws_req", {31'd0, IMem_Req}, 32'd1);
      tick();
      check("ws_nop", Instr1_OUT, NOP);
      check("ws_pc", Instr_PC_OUT, ea - 32'd4);
      check("ws_cnt", Fetch_Count, exp_cnt);
    end
    check("ws_addr", IMem_Addr, ea);
    drive(1'b1, ea | 32'd1, 1'b0, 1'b0, 32'd0);
    push(ea | 32'd1, ea);
    tick();
    pop_check("ws");
    ea = ea + 32'd4;

    // Freeze for 3 cycles while the ack returns.
    check("frz_addr", IMem_Addr, ea);
    drive(1'b1, 32'h2402_000A, 1'b1, 1'b0, 32'd0);
    push(32'h2402_000A, ea);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_instr", Instr1_OUT, (ea - 32'd4) | 32'd1);
      check("frz_pc", Instr_PC_OUT, ea - 32'd4);
      check("frz_req", {31'd0, IMem_Req}, 32'd0);
      check("frz_cnt", Fetch_Count, exp_cnt);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    pop_check("frz_rel");
    ea = ea + 32'd4;
    check("frz_next_addr", IMem_Addr, ea);
    check("frz_next_req", {31'd0, IMem_Req}, 32'd1);

    // Freeze with no ack in FETCH: outputs hold rather than going to NOP.
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    tick();
    check("frz_noack_instr", Instr1_OUT, 32'h2402_000A);
    check("frz_noack_addr", IMem_Addr, ea);

    // Redirect held 2 cycles during an outstanding request, ack arrives later.
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0040_0103);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("drain_nop", Instr1_OUT, NOP);
      check("drain_addr", IMem_Addr, ea);
      check("drain_req", {31'd0, IMem_Req}, 32'd1);
    end
    drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'd0);
    tick();
    check("drain_ack_nop", Instr1_OUT, NOP);
    check("drain_ack_cnt", Fetch_Count, exp_cnt);
    ea = 32'h0040_0100;
    check("drain_tgt_addr", IMem_Addr, ea);
    drive(1'b1, ea | 32'd1, 1'b0, 1'b0, 32'd0);
    push(ea | 32'd1, ea);
    tick();
    pop_check("after_redir");
    ea = ea + 32'd4;

    // Redirect with immediate ack, level held 2 cycles: one squash only.
    drive(1'b1, ea | 32'd1, 1'b0, 1'b1, 32'h0040_0203);
    tick();
    check("redir_ack_nop", Instr1_OUT, NOP);
    ea = 32'h0040_0200;
    check("redir_ack_addr", IMem_Addr, ea);
    drive(1'b1, ea | 32'd1, 1'b0, 1'b1, 32'h0040_0203);
    push(ea | 32'd1, ea);
    tick();
    pop_check("redir_once");
    ea = ea + 32'd4;

    // PC wrap at the top of the address space.
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    check("idle_nop", Instr1_OUT, NOP);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    ea = 32'hFFFF_FFFC;
    check("wrap_addr", IMem_Addr, ea);
    drive(1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'd0);
    push(32'h0000_0011, ea);
    tick();
    pop_check("wrap");
    ea = ea + 32'd4;
    check("wrap_next_addr", IMem_Addr, ea);

    // Redirect while in HOLD outranks a held freeze.
    drive(1'b1, 32'h0000_0099, 1'b1, 1'b0, 32'd0);
    tick();
    check("hold_req", {31'd0, IMem_Req}, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h0040_0300);
    tick();
    check("hold_redir_nop", Instr1_OUT, NOP);
    check("hold_redir_cnt", Fetch_Count, exp_cnt);
    check("hold_redir_addr", IMem_Addr, 32'h0040_0300);
    check("hold_redir_req", {31'd0, IMem_Req}, 32'd1);

    // Reset mid-transaction takes effect immediately.
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    RESET = 1'b1; #1;
    chk_reset("rst_mid");
    tick();
    RESET = 1'b0; #1;
    check("rst_mid_req", {31'd0, IMem_Req}, 32'd1);
    check("rst_mid_addr", IMem_Addr, RST_PC);
    exp_cnt = 32'd0;
    sb_q.delete();
    ea = RST_PC;
    drive(1'b1, ea | 32'd1, 1'b0, 1'b0, 32'd0);
    push(ea | 32'd1, ea);
    tick();
    pop_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 5-stage MIPS pipeline and the upstream end of the fetch/decode interface. It owns the PC and issues requests to instruction memory over a request/acknowledge handshake. It presents instruction, PC and PC+4 to decode, and honours decode's branch/jump redirect (`Alt_PC`/`Request_Alt_PC`) and stall (`WANT_FREEZE`) requests.

## Interface
Parameters:
- `RESET_PC`, default 32'h0040_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0000: bubble instruction sent to decode.

Ports:
- `CLK`  in  1  pipeline clock; all state changes on rising edge.
- `RESET`  in  1  reset, asynchronous, active-high.
- `Alt_PC`  in  32  redirect target from decode. Bits [1:0] are ignored and forced to 0.
- `Request_Alt_PC`  in  1  redirect request from decode (registered on decode's side).
- `WANT_FREEZE`  in  1  decode stall; fetch outputs must hold.
- `IMem_Addr`  out  32  instruction memory address.
- `IMem_Req`  out  1  request valid.
- `IMem_Ack`  in  1  response valid; `IMem_Data` is valid in the same cycle.
- `IMem_Data`  in  32  instruction word.
- `Instr1_OUT`  out  32  instruction to decode.
- `Instr_PC_OUT`  out  32  PC of `Instr1_OUT`.
- `Instr_PC_Plus4_OUT`  out  32  `Instr_PC_OUT` + 4.
- `Fetch_Count`  out  32  count of instructions delivered to decode (debug); wraps.

## Operation
- Internal registers:
  - `pc`: next fetch address.
  - `state`: FETCH, HOLD or DRAIN.
  - `hold_instr`/`hold_pc`: one-entry buffer.
  - `redir_pc`.
  - `redir_seen`: one-shot guard.
- Memory contract: while `IMem_Req`=1, `IMem_Addr` stays constant until the cycle `IMem_Ack`=1. `IMem_Req` = (state==FETCH or DRAIN) and not in reset.
  - In FETCH, `IMem_Addr` = `pc`.
  - In DRAIN, `IMem_Addr` holds the address of the abandoned request.
- A redirect is "new" when `Request_Alt_PC`=1 and `redir_seen`=0.
  - A new redirect sets `redir_seen`.
  - `redir_seen` clears when `Request_Alt_PC`=0.
  - A level held high for N cycles therefore redirects once.
- State behaviour, in priority order.
- **FETCH**
  - New redirect with Ack: discard data, `Instr1_OUT`<=NOP, `pc`<={Alt_PC[31:2],2'b00}, stay in FETCH.
  - New redirect without Ack: `redir_pc`<=aligned `Alt_PC`, `Instr1_OUT`<=NOP, go to DRAIN.
  - `WANT_FREEZE`=1 with Ack: `hold_instr`<=`IMem_Data`, `hold_pc`<=`pc`, `pc`<=`pc`+4, go to HOLD. Decode outputs hold.
  - `WANT_FREEZE`=1 without Ack: decode outputs hold, stay in FETCH.
  - Ack, no freeze: `Instr1_OUT`<=`IMem_Data`, `Instr_PC_OUT`<=`pc`, `Instr_PC_Plus4_OUT`<=`pc`+4, `pc`<=`pc`+4, `Fetch_Count`++.
  - No Ack, no freeze: `Instr1_OUT`<=NOP; the PC outputs keep their values; `Fetch_Count` is unchanged.
- **HOLD** (`IMem_Req`=0)
  - New redirect: drop the buffer, `Instr1_OUT`<=NOP, `pc`<=aligned `Alt_PC`, go to FETCH.
  - `WANT_FREEZE`=1: outputs hold.
  - `WANT_FREEZE`=0: present `hold_instr`/`hold_pc`/`hold_pc`+4, `Fetch_Count`++, go to FETCH.
- **DRAIN**
  - Outputs: `Instr1_OUT`<=NOP each cycle, unless `WANT_FREEZE`=1, in which case outputs hold.
  - On Ack: discard data, `pc`<=`redir_pc`, go to FETCH.
  - A further new redirect while in DRAIN overwrites `redir_pc`.
- Redirect outranks freeze in every state.
- Arithmetic: PC adds are 32-bit modulo; 32'hFFFF_FFFC + 4 = 0. `Fetch_Count` wraps at 2^32.

## Timing
- Reset, asynchronous, while `RESET`=1:
  - Outputs: `Instr1_OUT`=NOP, `Instr_PC_OUT`=0, `Instr_PC_Plus4_OUT`=0, `Fetch_Count`=0, `IMem_Req`=0, `IMem_Addr`=`RESET_PC`.
  - Internal: `pc`=`RESET_PC`, state=FETCH, `redir_seen`=0, buffers=0.
- First request: `IMem_Req`=1 in the first cycle after `RESET` falls.
- Reset asserted mid-transaction: abandons the request immediately; no drain.
- Latency: Ack at edge k means the instruction appears on `Instr1_OUT` after edge k (1 cycle registered).
- Throughput: zero-wait memory sustains 1 instruction/cycle.
- Delay slot: decode's registered redirect arrives while the instruction after the delay slot is being fetched. That fetch is always squashed, so decode sees exactly one NOP before the target (zero-wait memory).
- Freeze: effective in the same cycle it is sampled. Outputs are unchanged at the following edge.

## Test plan
- Reset: `RESET`=1 mid-run with `RESET_PC`=32'h0040_0000 -> all outputs at reset values immediately. After release, cycle 1 shows `IMem_Req`=1, `IMem_Addr`=32'h0040_0000.
- Streaming: Ack every cycle, `IMem_Data`=addr|1 -> `Instr1_OUT` = 32'h0040_0001, _0005, _0009 on consecutive cycles; `Instr_PC_Plus4_OUT` = 32'h0040_0004, _0008, _000C; `Fetch_Count`=3.
- Wait states: Ack 2 cycles late on 32'h0040_0004 -> `IMem_Addr` held 3 cycles; two NOPs to decode; then the instruction with `Instr_PC_OUT`=32'h0040_0004.
- Freeze: `WANT_FREEZE`=1 for 3 cycles while Ack returns 32'h2402_000A -> decode outputs frozen and `IMem_Req`=0 in HOLD. After release, `Instr1_OUT`=32'h2402_000A, and the next request address is that instruction's PC+4.
- Redirect during an outstanding request: `Request_Alt_PC`=1 held 2 cycles, `Alt_PC`=32'h0040_0103, Ack 2 cycles later -> old address held until Ack, its data discarded as NOP, next `IMem_Addr`=32'h0040_0100, exactly one redirect.
- Wrap: `pc`=32'hFFFF_FFFC with Ack -> `Instr_PC_Plus4_OUT`=0, next `IMem_Addr`=0.
